// File: rtl/noc_link_mc_pkg.sv
// noc_link_mc_pkg: shared widths, flit type and parity helper for the multi-channel link PHY
package noc_link_mc_pkg;
  localparam int PAR_MAX = 1024;
  localparam int DEF_HDR = 4;
  localparam int DEF_PAY = 64;
  typedef struct packed {
    logic [DEF_HDR-1:0] header;
    logic [DEF_PAY-1:0] payload;
  } flit_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int flit_w(input int hdr, input int pay);
    return hdr + pay;
  endfunction
  function automatic int ch_w(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
  function automatic logic parity(input logic [PAR_MAX-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/noc_link_mc_fifo.sv
// noc_link_mc_fifo: synchronous show-ahead FIFO; the head reads as zero while empty
module noc_link_mc_fifo import noc_link_mc_pkg::*; #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 68,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty_o = count_o == '0;
  assign full_o  = count_o == CW'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wr_ptr] <= din_i;
endmodule

// File: rtl/noc_link_mc_phy.sv
// noc_link_mc_phy: NUM_CH virtual channels over one flit link with round-robin arbitration and credit flow control.
// Define NOC_LINK_PARITY_EN to generate and check link parity; otherwise the parity pins are inert.
module noc_link_mc_phy import noc_link_mc_pkg::*; #(
  parameter  int NOC_HEADER_SIZE  = 4,
  parameter  int NOC_PAYLOAD_SIZE = 64,
  parameter  int NUM_CH           = 2,
  parameter  int TX_DEPTH         = 4,
  parameter  int RX_DEPTH         = 4,
  localparam int FLIT_W           = flit_w(NOC_HEADER_SIZE, NOC_PAYLOAD_SIZE),
  localparam int CH_W             = ch_w(NUM_CH)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_CH-1:0]                  tx_wrreq_i,
  input  logic [NUM_CH*NOC_HEADER_SIZE-1:0]  tx_header_i,
  input  logic [NUM_CH*NOC_PAYLOAD_SIZE-1:0] tx_payload_i,
  output logic [NUM_CH-1:0]                  tx_stall_o,
  output logic                               link_valid_o,
  output logic [CH_W-1:0]                    link_ch_o,
  output logic [FLIT_W-1:0]                  link_flit_o,
  output logic                               link_par_o,
  input  logic [NUM_CH-1:0]                  link_credit_i,
  input  logic                               link_valid_i,
  input  logic [CH_W-1:0]                    link_ch_i,
  input  logic [FLIT_W-1:0]                  link_flit_i,
  input  logic                               link_par_i,
  output logic [NUM_CH-1:0]                  link_credit_o,
  input  logic [NUM_CH-1:0]                  rx_rdreq_i,
  output logic [NUM_CH*NOC_HEADER_SIZE-1:0]  rx_header_o,
  output logic [NUM_CH*NOC_PAYLOAD_SIZE-1:0] rx_payload_o,
  output logic [NUM_CH-1:0]                  rx_fifo_empty_o,
  output logic [NUM_CH-1:0]                  rx_overflow_o,
  output logic                               rx_parity_err_o
);
  localparam int CW  = clog2(RX_DEPTH + 1);
  localparam int TCW = clog2(TX_DEPTH + 1);
  localparam int TW  = CW + 1;
  localparam int H   = NOC_HEADER_SIZE;
  localparam int P   = NOC_PAYLOAD_SIZE;
  logic [FLIT_W-1:0] tx_dout [NUM_CH];
  logic [FLIT_W-1:0] rx_dout [NUM_CH];
  logic [TCW-1:0] unused_tx_cnt [NUM_CH];
  logic [CW-1:0] unused_rx_cnt [NUM_CH];
  logic [CW-1:0] cnt [NUM_CH];
  logic [CW-1:0] cnt_nxt [NUM_CH];
  logic [CW-1:0] owe [NUM_CH];
  logic [TW-1:0] tot [NUM_CH];
  logic [NUM_CH-1:0] tx_full, tx_empty, rx_full, rx_empty, rx_push, rx_pop, perr, elig, gnt;
  logic [CH_W-1:0] last_grant, gnt_id;
  logic gnt_v, par_ok;
  int idx;
  assign tx_stall_o      = tx_full;
  assign rx_fifo_empty_o = rx_empty;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    noc_link_mc_fifo #(.DEPTH(TX_DEPTH), .WIDTH(FLIT_W)) u_tx (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_wrreq_i[g] && !tx_full[g]), .pop_i(gnt[g]),
      .din_i({tx_header_i[g*H +: H], tx_payload_i[g*P +: P]}),
      .dout_o(tx_dout[g]), .full_o(tx_full[g]), .empty_o(tx_empty[g]), .count_o(unused_tx_cnt[g]));
    noc_link_mc_fifo #(.DEPTH(RX_DEPTH), .WIDTH(FLIT_W)) u_rx (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push[g]), .pop_i(rx_rdreq_i[g]),
      .din_i(link_flit_i), .dout_o(rx_dout[g]), .full_o(rx_full[g]), .empty_o(rx_empty[g]),
      .count_o(unused_rx_cnt[g]));
    assign elig[g]    = !tx_empty[g] && cnt[g] != '0;
    assign gnt[g]     = gnt_v && gnt_id == CH_W'(g);
    assign rx_push[g] = link_valid_i && link_ch_i == CH_W'(g) && par_ok;
    assign perr[g]    = link_valid_i && link_ch_i == CH_W'(g) && !par_ok;
    assign rx_pop[g]  = rx_rdreq_i[g] && !rx_empty[g];
    assign rx_header_o[g*H +: H]  = rx_dout[g][FLIT_W-1 -: H];
    assign rx_payload_o[g*P +: P] = rx_dout[g][P-1:0];
    assign cnt_nxt[g] = (link_credit_i[g] == gnt[g]) ? cnt[g] :
                        gnt[g] ? cnt[g] - CW'(1) :
                        cnt[g] == CW'(RX_DEPTH) ? cnt[g] : cnt[g] + CW'(1);
    // credits owed back to the partner; a pop and a parity drop together need two pulses
    assign tot[g] = TW'(owe[g]) + TW'(rx_pop[g]) + TW'(perr[g]);
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(link_credit_i[g] && !gnt[g] && cnt[g] == CW'(RX_DEPTH)));
  end
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!gnt_v && elig[CH_W'(idx)]) begin
        gnt_v  = 1'b1;
        gnt_id = CH_W'(idx);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant    <= CH_W'(NUM_CH - 1);
      link_valid_o  <= 1'b0;
      link_ch_o     <= '0;
      link_flit_o   <= '0;
      link_credit_o <= '0;
      rx_overflow_o <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= CW'(RX_DEPTH);
        owe[c] <= '0;
      end
    end else begin
      link_valid_o <= gnt_v;
      if (gnt_v) begin
        last_grant  <= gnt_id;
        link_ch_o   <= gnt_id;
        link_flit_o <= tx_dout[gnt_id];
      end
      rx_overflow_o <= rx_overflow_o | (rx_push & rx_full & ~rx_pop);
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]           <= cnt_nxt[c];
        link_credit_o[c] <= tot[c] != '0;
        owe[c]           <= tot[c] == '0 ? '0 : CW'(tot[c] - TW'(1));
      end
    end
  end
`ifdef NOC_LINK_PARITY_EN
  assign par_ok = parity(PAR_MAX'({link_ch_i, link_flit_i})) == link_par_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      link_par_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
    end else begin
      if (gnt_v) link_par_o <= parity(PAR_MAX'({gnt_id, tx_dout[gnt_id]}));
      if (link_valid_i && !par_ok) rx_parity_err_o <= 1'b1;
    end
  end
`else
  logic unused_par;
  assign unused_par      = link_par_i;
  assign par_ok          = 1'b1;
  assign link_par_o      = 1'b0;
  assign rx_parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_noc_link_mc_phy.sv
// tb_noc_link_mc_phy: directed scoreboard bench for noc_link_mc_phy with NUM_CH=2.
// Parity steps run only when NOC_LINK_PARITY_EN is defined.
module tb_noc_link_mc_phy;
  import noc_link_mc_pkg::*;
  localparam int FW = 68;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] tx_wrreq_i = '0;
  logic [7:0] tx_header_i = '0;
  logic [127:0] tx_payload_i = '0;
  logic [1:0] tx_stall_o;
  logic link_valid_o, link_ch_o, link_par_o;
  logic [FW-1:0] link_flit_o;
  logic [1:0] link_credit_i, link_credit_o;
  logic link_valid_i, link_ch_i, link_par_i;
  logic [FW-1:0] link_flit_i;
  logic [1:0] rx_rdreq_i = '0;
  logic [7:0] rx_header_o;
  logic [127:0] rx_payload_o;
  logic [1:0] rx_fifo_empty_o, rx_overflow_o;
  logic rx_parity_err_o;
  logic loop = 1'b1, flip_par = 1'b0, inj_valid = 1'b0, inj_ch = 1'b0;
  logic [FW-1:0] inj_flit = '0;
  int n_pass = 0, n_chk = 0;
  flit_t tq0[$], tq1[$], rq0[$], rq1[$];
  flit_t last_wr [2];
  logic sent_ch[$];
  logic [7:0] ord;
  flit_t d1, d2;

  assign link_valid_i  = loop ? link_valid_o : inj_valid;
  assign link_ch_i     = loop ? link_ch_o : inj_ch;
  assign link_flit_i   = loop ? link_flit_o : inj_flit;
  assign link_par_i    = loop ? (link_par_o ^ flip_par) : ^{inj_ch, inj_flit};
  assign link_credit_i = loop ? link_credit_o : 2'b00;

  noc_link_mc_phy dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_wrreq_i(tx_wrreq_i), .tx_header_i(tx_header_i),
    .tx_payload_i(tx_payload_i), .tx_stall_o(tx_stall_o), .link_valid_o(link_valid_o),
    .link_ch_o(link_ch_o), .link_flit_o(link_flit_o), .link_par_o(link_par_o),
    .link_credit_i(link_credit_i), .link_valid_i(link_valid_i), .link_ch_i(link_ch_i),
    .link_flit_i(link_flit_i), .link_par_i(link_par_i), .link_credit_o(link_credit_o),
    .rx_rdreq_i(rx_rdreq_i), .rx_header_o(rx_header_o), .rx_payload_o(rx_payload_o),
    .rx_fifo_empty_o(rx_fifo_empty_o), .rx_overflow_o(rx_overflow_o),
    .rx_parity_err_o(rx_parity_err_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  // link monitor: every flit on the link must be the oldest one written on its channel
  always @(negedge clk_i) begin
    if (!rst_i && link_valid_o) begin
      flit_t e;
      e = '1;
      sent_ch.push_back(link_ch_o);
      if (!link_ch_o && tq0.size() > 0) e = tq0.pop_front();
      if (link_ch_o && tq1.size() > 0) e = tq1.pop_front();
      chk("link_flit", 128'(link_flit_o), 128'(e));
      if (loop && !flip_par) begin
        if (link_ch_o) rq1.push_back(e);
        else rq0.push_back(e);
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    tx_wrreq_i = '0;
    rx_rdreq_i = '0;
    inj_valid = 1'b0;
    flip_par = 1'b0;
    loop = 1'b1;
    tick(2);
    rst_i = 1'b0;
    tq0.delete();
    tq1.delete();
    rq0.delete();
    rq1.delete();
    sent_ch.delete();
  endtask

  task automatic wr(input logic [1:0] chs, input bit rec);
    tx_wrreq_i = chs;
    for (int c = 0; c < 2; c++) begin
      flit_t f;
      f.header = 4'($urandom);
      f.payload = {$urandom, $urandom};
      tx_header_i[c*4 +: 4] = f.header;
      tx_payload_i[c*64 +: 64] = f.payload;
      if (chs[c] && rec) begin
        last_wr[c] = f;
        if (c == 0) tq0.push_back(f);
        else tq1.push_back(f);
      end
    end
    tick();
    tx_wrreq_i = '0;
  endtask

  task automatic pop(input int ch);
    flit_t e;
    e = '1;
    if (ch == 0 && rq0.size() > 0) e = rq0.pop_front();
    if (ch == 1 && rq1.size() > 0) e = rq1.pop_front();
    chk("rx_nonempty", 128'(rx_fifo_empty_o[ch]), 128'(0));
    chk("rx_head", 128'({rx_header_o[ch*4 +: 4], rx_payload_o[ch*64 +: 64]}), 128'(e));
    rx_rdreq_i[ch] = 1'b1;
    tick();
    rx_rdreq_i[ch] = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_empty", 128'(rx_fifo_empty_o), 128'(2'b11));
    chk("rst_stall", 128'(tx_stall_o), 128'(0));
    chk("rst_valid", 128'(link_valid_o), 128'(0));
    chk("rst_credit_o", 128'(link_credit_o), 128'(0));
    chk("rst_ovf", 128'(rx_overflow_o), 128'(0));
    chk("rst_perr", 128'(rx_parity_err_o), 128'(0));
    chk("rst_rx_data", 128'({rx_header_o, rx_payload_o}), 128'(0));
    chk("rst_cnt0", 128'(dut.cnt[0]), 128'(4));
    chk("rst_cnt1", 128'(dut.cnt[1]), 128'(4));
    // single flit on ch0, looped back into RX
    wr(2'b01, 1'b1);
    chk("lat_c1_valid", 128'(link_valid_o), 128'(0));
    tick();
    chk("lat_c2_valid", 128'(link_valid_o), 128'(1));
    chk("lat_c2_ch", 128'(link_ch_o), 128'(0));
    chk("lat_c2_cnt0", 128'(dut.cnt[0]), 128'(3));
`ifdef NOC_LINK_PARITY_EN
    chk("lat_c2_par", 128'(link_par_o), 128'(^{1'b0, last_wr[0]}));
`else
    chk("lat_c2_par", 128'(link_par_o), 128'(0));
`endif
    tick();
    chk("lat_c3_empty", 128'(rx_fifo_empty_o), 128'(2'b10));
    pop(0);
    chk("pop_credit", 128'(link_credit_o), 128'(2'b01));
    chk("pop_empty", 128'(rx_fifo_empty_o), 128'(2'b11));
    tick();
    chk("pop_credit_off", 128'(link_credit_o), 128'(0));
    chk("pop_cnt0", 128'(dut.cnt[0]), 128'(4));
    chk("perr_quiet", 128'(rx_parity_err_o), 128'(0));
    // both channels, four flits each, no consumer
    do_reset();
    for (int i = 0; i < 4; i++) wr(2'b11, 1'b1);
    tick(12);
    chk("rr_count", 128'(sent_ch.size()), 128'(8));
    ord = '0;
    for (int i = 0; i < 8 && i < sent_ch.size(); i++) ord[i] = sent_ch[i];
    chk("rr_order", 128'(ord), 128'(8'hAA));
    chk("rr_valid_idle", 128'(link_valid_o), 128'(0));
    chk("rr_rx_full", 128'(rx_fifo_empty_o), 128'(0));
    chk("rr_ovf", 128'(rx_overflow_o), 128'(0));
    chk("rr_cnt0", 128'(dut.cnt[0]), 128'(0));
    chk("rr_cnt1", 128'(dut.cnt[1]), 128'(0));
    // fill TX ch1 with no credits left, then try one write while stalled
    for (int i = 0; i < 4; i++) wr(2'b10, 1'b1);
    chk("stall_set", 128'(tx_stall_o), 128'(2'b10));
    wr(2'b10, 1'b0);
    tick(3);
    chk("stall_no_send", 128'(sent_ch.size()), 128'(8));
    chk("stall_hold", 128'(tx_stall_o), 128'(2'b10));
    pop(1);
    chk("cr1_credit", 128'(link_credit_o), 128'(2'b10));
    tick();
    chk("cr1_wait", 128'(link_valid_o), 128'(0));
    tick();
    chk("cr1_valid", 128'(link_valid_o), 128'(1));
    chk("cr1_ch", 128'(link_ch_o), 128'(1));
    chk("cr1_stall_clr", 128'(tx_stall_o), 128'(0));
    tick(3);
    chk("cr1_one_flit", 128'(sent_ch.size()), 128'(9));
    chk("cr1_ovf", 128'(rx_overflow_o), 128'(0));
    chk("cr1_cnt1", 128'(dut.cnt[1]), 128'(0));
    // injected flits into the full RX ch0
    loop = 1'b0;
    d1 = {4'h5, 64'h1111_2222_3333_4444};
    d2 = {4'hA, 64'hDEAD_BEEF_0BAD_F00D};
    inj_ch = 1'b0;
    inj_flit = d1;
    inj_valid = 1'b1;
    rq0.push_back(d1);
    pop(0);
    inj_valid = 1'b0;
    chk("full_pushpop_ovf", 128'(rx_overflow_o), 128'(0));
    inj_flit = d2;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    chk("ovf_set", 128'(rx_overflow_o), 128'(2'b01));
    tick(2);
    for (int i = 0; i < 4; i++) pop(0);
    chk("ovf_drained", 128'(rx_fifo_empty_o), 128'(2'b01));
    chk("ovf_sticky", 128'(rx_overflow_o), 128'(2'b01));
    do_reset();
    chk("ovf_rst", 128'(rx_overflow_o), 128'(0));
    chk("rst2_empty", 128'(rx_fifo_empty_o), 128'(2'b11));
    chk("rst2_cnt1", 128'(dut.cnt[1]), 128'(4));
    rx_rdreq_i = 2'b01;
    tick();
    rx_rdreq_i = '0;
    chk("pop_empty_no_credit", 128'(link_credit_o), 128'(0));
`ifdef NOC_LINK_PARITY_EN
    flip_par = 1'b1;
    wr(2'b10, 1'b1);
    tick();
    chk("par_valid", 128'(link_valid_o), 128'(1));
    chk("par_ch", 128'(link_ch_o), 128'(1));
    tick();
    chk("par_dropped", 128'(rx_fifo_empty_o), 128'(2'b11));
    chk("par_err", 128'(rx_parity_err_o), 128'(1));
    chk("par_credit", 128'(link_credit_o), 128'(2'b10));
    tick();
    flip_par = 1'b0;
    chk("par_credit_off", 128'(link_credit_o), 128'(0));
    chk("par_cnt1", 128'(dut.cnt[1]), 128'(4));
    chk("par_sticky", 128'(rx_parity_err_o), 128'(1));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
